// File: rtl/rv32i_pkg.sv
// rv32i_pkg: constants shared by the RV32I fetch front end.
//   XLEN_DEFAULT      default address / PC width
//   INSTR_W           instruction word width
//   PC_STEP           byte distance between sequential fetches
//   RESET_PC_DEFAULT  default first fetch address after reset
//   cnt_w()           width of a counter that must hold 0..depth
package rv32i_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam int          INSTR_W          = 32;
  localparam int          PC_STEP          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: instruction-memory request/response bus plus the decode
// handshake of the fetch queue.
//   imaddr_out/imreq_out      fetch address and request (fetch unit drives)
//   imgnt_in                  memory accepts the request this cycle
//   imvalid_in/imdata_in      in-order response from memory
//   instr_valid_out/instr_out/instr_pc_out  queue head towards decode
//   instr_ready_in            decode consumes the head
// master = fetch unit side, slave = memory/decode environment side.
interface ifetch_queue_if
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic [XLEN-1:0]    imaddr_out;
  logic               imreq_out;
  logic               imgnt_in;
  logic               imvalid_in;
  logic [INSTR_W-1:0] imdata_in;
  logic               instr_valid_out;
  logic [INSTR_W-1:0] instr_out;
  logic [XLEN-1:0]    instr_pc_out;
  logic               instr_ready_in;

  modport master (
    output imaddr_out, imreq_out,
    input  imgnt_in, imvalid_in, imdata_in,
    output instr_valid_out, instr_out, instr_pc_out,
    input  instr_ready_in
  );

  modport slave (
    input  imaddr_out, imreq_out,
    output imgnt_in, imvalid_in, imdata_in,
    input  instr_valid_out, instr_out, instr_pc_out,
    output instr_ready_in
  );
endinterface

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous FIFO with clear and occupancy count.
//   clk_in, rst_in     clock, asynchronous active-low reset
//   clear_in           empties the FIFO (dominates push/pop)
//   push_in/data_in    write; caller guarantees not full
//   pop_in             advance head; caller guarantees not empty
//   data_out           head entry (first-word fall-through)
//   count_out          entries held, 0..DEPTH
//   empty_out          count_out == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count_out,
  output logic             empty_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_in) begin
        mem_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_in) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_in) - CW'(pop_in);
    end
  end

  assign data_out  = mem_q[rd_ptr_q];
  assign count_out = count_q;
  assign empty_out = (count_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: request/response instruction fetch engine with a prefetch
// queue between the PC redirect sources and decode.
//   clk_in, rst_in            clock, asynchronous active-low reset
//   redirect_in               taken branch/jump: flush and refetch
//   redirect_pc_in            new PC (bits [1:0] ignored)
//   bus (ifetch_queue_if.master)  memory request/response and decode handshake
// Build option IFQ_BYPASS_EN: a response arriving at an empty, clean queue is
// presented to decode in the same cycle; without it every output is
// registered and imdata_in has no combinational path to instr_out.
module ifetch_queue
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  ifetch_queue_if.master  bus
);

  localparam int CW = cnt_w(DEPTH);
  localparam int QW = XLEN + INSTR_W;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic            run_q;

  logic            q_push, q_pop, q_empty;
  logic [QW-1:0]   q_dout;
  logic [CW-1:0]   q_count;
  logic [XLEN-1:0] pc_head;
  logic [CW-1:0]   pc_count;
  logic            pc_empty;

  logic [CW:0]     in_use;
  logic            issue, resp_drop, resp_own, resp_accept;

  // run_q holds the request off for the first edge after reset release.
  assign in_use        = {1'b0, q_count} + {1'b0, outst_q};
  assign bus.imreq_out = run_q && (in_use < DEPTH_V) && !redirect_in;
  assign bus.imaddr_out = fetch_pc_q;
  assign issue         = bus.imreq_out && bus.imgnt_in;

  assign resp_drop   = bus.imvalid_in && (disc_q != '0);
  assign resp_own    = bus.imvalid_in && (disc_q == '0) && (outst_q != '0);
  assign resp_accept = resp_own && !redirect_in;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass              = q_empty && resp_accept;
  assign bus.instr_valid_out = bypass || (!q_empty && !redirect_in);
  assign bus.instr_out       = bypass ? bus.imdata_in : q_dout[INSTR_W-1:0];
  assign bus.instr_pc_out    = bypass ? pc_head : q_dout[QW-1:INSTR_W];
  assign q_push              = resp_accept && !(bypass && bus.instr_ready_in);
`else
  assign bus.instr_valid_out = !q_empty && !redirect_in;
  assign bus.instr_out       = q_dout[INSTR_W-1:0];
  assign bus.instr_pc_out    = q_dout[QW-1:INSTR_W];
  assign q_push              = resp_accept;
`endif
  assign q_pop = !q_empty && !redirect_in && bus.instr_ready_in;

  // A response in the redirect cycle is charged to whichever counter owns it
  // before the outstanding fetches are moved over to the discard count.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    if (redirect_in) begin
      fetch_pc_d = {redirect_pc_in[XLEN-1:2], 2'b00};
      outst_d    = '0;
      disc_d     = disc_q + outst_q - CW'(resp_drop || resp_own);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      outst_d = outst_q + CW'(issue) - CW'(resp_accept);
      disc_d  = disc_q - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      run_q      <= 1'b1;
    end
  end

  ifq_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_instr_q (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear_in  (redirect_in),
    .push_in   (q_push),
    .data_in   ({pc_head, bus.imdata_in}),
    .pop_in    (q_pop),
    .data_out  (q_dout),
    .count_out (q_count),
    .empty_out (q_empty)
  );

  // PCs of live fetches in issue order; the head belongs to the next response.
  ifq_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear_in  (redirect_in),
    .push_in   (issue),
    .data_in   (fetch_pc_q),
    .pop_in    (resp_accept),
    .data_out  (pc_head),
    .count_out (pc_count),
    .empty_out (pc_empty)
  );

`ifndef SYNTHESIS
  a_orphan_resp: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(bus.imvalid_in && (outst_q == '0) && (disc_q == '0)));
  a_pc_q_tracks: assert property (@(posedge clk_in) disable iff (!rst_in)
    pc_count == outst_q);
  a_pc_q_head: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(resp_accept && pc_empty));
`endif

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch front end for the RV32I core: it replaces the single-cycle PC/instruction-memory path with a request/response fetch engine and a prefetch queue of configurable depth. It sits between the PC redirect sources (branch unit and jump target from the immediate adder) and the decode stage. It tolerates instruction memory with any response latency of one cycle or more, and discards in-flight fetches cleanly on redirect.

## Interface
- XLEN, 32, address and PC width.
- DEPTH, 4, queue entries and maximum outstanding fetches; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

- clk_in  input  1  single clock; all state on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- imaddr_out  output  XLEN  fetch address; word aligned.
- imreq_out  output  1  fetch request valid.
- imgnt_in  input  1  memory accepts request this cycle; a fetch is issued when imreq_out && imgnt_in.
- imvalid_in  input  1  response valid; responses return in issue order.
- imdata_in  input  32  response instruction word.
- redirect_in  input  1  taken branch/jump; flush and refetch.
- redirect_pc_in  input  XLEN  new PC; bits [1:0] ignored and treated as 0.
- instr_valid_out  output  1  queue head valid.
- instr_out  output  32  head instruction.
- instr_pc_out  output  XLEN  PC of head instruction.
- instr_ready_in  input  1  decode consumes head when instr_valid_out && instr_ready_in.

## Operation
- State: fetch_pc, FIFO of {pc, instr}, outstanding counter, discard counter. Counters are $clog2(DEPTH)+1 bits wide.
- Credit rule: imreq_out = (occupancy + outstanding < DEPTH) && !redirect_in.
- imaddr_out = fetch_pc. On issue, fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding increments.
- Response handling:
  - If discard > 0: the response is dropped and discard decrements.
  - Otherwise: {pc, imdata_in} is pushed and outstanding decrements.
  - Response PCs come from a PC side-FIFO written at issue.
- Redirect (redirect_in = 1):
  - Next cycle: fetch_pc = {redirect_pc_in[XLEN-1:2], 2'b00}, queue and PC side-FIFO emptied, discard += outstanding, outstanding = 0.
  - Any response arriving in the redirect cycle is also discarded (it counts against the old outstanding).
  - instr_valid_out is forced 0 combinationally in the redirect cycle; no pop occurs.
- Queue is never full when a push arrives, guaranteed by the credit rule. Pop and push in the same cycle are allowed at any occupancy.
- imvalid_in with outstanding = 0 and discard = 0 is a protocol error: ignored, and flagged by assertion in simulation.
- A redirect while discard > 0 accumulates: discard = discard + outstanding.

## Timing
- Reset values: imreq_out 0, imaddr_out RESET_PC, instr_valid_out 0, instr_out 0, instr_pc_out 0, all counters 0.
- imreq_out first rises in the first clk_in edge cycle after rst_in deasserts.
- Latency without bypass: response at edge N → instr_valid_out at cycle N+1.
- Redirect latency: redirect_in at cycle N → imaddr_out = new PC with imreq_out high in cycle N+1 (credit permitting).
- Throughput: one instruction per cycle at sustained grant, if DEPTH ≥ memory latency + 1.
- Reset mid-operation: all state clears asynchronously. Responses for pre-reset requests must not be returned by memory; memory is reset by the same rst_in.

## Configuration
- IFQ_BYPASS_EN defined:
  - When the queue is empty, discard = 0, !redirect_in and imvalid_in = 1, the response drives instr_out/instr_pc_out/instr_valid_out combinationally in the same cycle.
  - If instr_ready_in is also 1, nothing is pushed; otherwise the response is pushed as normal.
- IFQ_BYPASS_EN undefined: all outputs come from FIFO registers with one-cycle latency, and there is no combinational path from imdata_in to instr_out.

## Structure
- Shared package rv32i_pkg: XLEN default, INSTR_W = 32, PC_STEP = 4, RESET_PC default.
- Sub-module ifq_fifo: parametrised synchronous FIFO (width, DEPTH) with push/pop/clear and count. It is instantiated twice: once for the {pc, instr} queue and once for the issued-PC side-FIFO.
- Counters, credit and redirect logic live in ifetch_queue.

## Test plan
- Reset, memory with imgnt_in = 1 and latency 1 → addresses 0x0, 0x4, 0x8 issued in consecutive cycles; instr_pc_out sequence 0x0, 0x4, 0x8, one instruction per cycle once streaming.
- DEPTH = 4, instr_ready_in = 0 → exactly 4 issues, then imreq_out stays 0. Raising instr_ready_in for one cycle → exactly one new issue.
- Latency 3, redirect to 0x100 with 2 fetches outstanding → both stale responses dropped; the first instr_pc_out after redirect is 0x100.
- redirect_pc_in = 0x203 → imaddr_out = 0x200.
- imgnt_in toggling every other cycle with random latency 1-5 → in-order, gap-free PC stream and no lost or duplicated instructions versus a reference model.
- Reset asserted mid-stream → all outputs return to reset values immediately; the first request after release is RESET_PC.
